school_seating_system: RTL and testbench
========================================

// Module: school_seating_system
// PURPOSE
//  Library/study-room seat reservation controller. Tracks owner, state and timestamp of
//  every seat. Handles occupy/away/release requests from a kiosk front end. Auto-releases
//  seats left "away" too long and records a strike against the owner. Bans repeat offenders.
//  Exposes a free-running time base.
// PARAMETERS
//  NUM_SEATS   32  seats tracked, index 0..NUM_SEATS-1 (Seat_No >= NUM_SEATS -> reject)
//  NUM_STU     8   student strike-table entries (fully associative on 32-bit Student_No)
//  TICK_DIV    1   clk cycles per Time increment
//  DEF_LIMIT   5   reset value of away time limit (Time ticks)
//  DEF_BAN     2   reset value of strike threshold (0 = banning disabled)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   reset, asynchronous, active-high
//  Student_No  in   32  requesting student ID
//  Seat_No     in   5   target seat
//  write       in   1   request strobe, sampled on rising clk
//  Time        out  11  current time tick counter
//  Seat_State  in   2   requested state: 0 release, 1 away, 2 occupy, 3 illegal (reject)
//  write_set   in   2   settings strobe: 1 load ban, 2 load limit_time, 3 clear strikes/bans, 0 idle
//  limit_time  in   11  new away limit, loaded when write_set==2
//  ban         in   2   new strike threshold, loaded when write_set==1
//  req_ok      out  1   one-cycle pulse, cycle after an accepted request
//  req_fail    out  1   one-cycle pulse, cycle after a rejected request
// BEHAVIOUR
//  - Reset:
//    * all seats state 0, owner 0, stamp 0; strike table empty; Time=0.
//    * lim=DEF_LIMIT, thr=DEF_BAN; req_ok=req_fail=0.
//  - Time: increments every TICK_DIV cycles; wraps 2047->0. Elapsed = (Time-stamp) mod 2048.
//  - Requests: one per cycle when write=1; result registered, req_ok/req_fail next cycle.
//  - Occupy (2): reject if student banned.
//    * Seat 0 and student holds no other seat -> state 2, owner=ID, stamp=Time, ok.
//    * Own seat in state 1 -> back to 2, ok.
//    * Own seat already 2 -> no change, ok.
//    * Other owner, or student holds a different seat -> reject.
//  - Away (1): own seat in state 2 -> state 1, stamp=Time, ok; else reject.
//  - Release (0): own seat in state 1 or 2 -> state 0, owner cleared, ok; else reject.
//  - Timeout: every cycle, any seat in state 1 with elapsed >= lim -> state 0, owner cleared.
//    * Owner's strike count +1 (saturates at 3); new entry allocated if absent.
//    * Table full -> overwrite entry 0.
//    * Multiple seats timing out in the same cycle: all are processed, each owner striked.
//  - Ban: student banned while thr!=0 and strikes >= thr (combinational on current thr).
//    Lowering thr takes effect immediately.
//  - Simultaneous write and timeout on the same seat: timeout wins; request evaluated on the
//    post-timeout state in the same cycle.
//  - Settings: write_set takes effect on the clock edge; a request in the same cycle uses the
//    old values. write_set==3 clears the strike table.
//  - rst mid-operation clears everything asynchronously; outputs low until next accepted request.
// TESTING
//  1. rst; occupy(ID 201819186, seat 1) -> req_ok; occupy(201912352, seat 1) -> req_fail.
//  2. 201912352 occupies seat 2, goes away, wait >=5 ticks -> seat 2 freed, strike=1;
//     occupy seat 2 again -> req_ok (thr=2, not banned).
//  3. write_set=2, limit_time=15: away 3 ticks on seat 5 then return -> req_ok, no strike.
//     Moving to seat 3 while still holding seat 5 -> req_fail.
//  4. 201912379 occupies seat 4 -> ok; then seat 7 -> fail (already holds seat).
//     Release by non-owner on seat 4 -> fail; release by owner -> ok.
//  5. Give a student 1 strike, write_set=1 ban=1 -> next occupy of free seat 6 -> req_fail;
//     write_set=3 -> same request req_ok.
//  6. Time wraps 2047->0 with seat away at stamp 2045, lim=5 -> released at Time=2; assert rst
//     mid-run -> all seats free, Time=0.

Source files
------------

// File: rtl/school_seating_system.sv
// rtl/school_seating_system.sv - seat reservation controller with away timeout and strike/ban tracking
//
// Purpose: keeps state/owner/stamp for every seat, serves occupy/away/release
// requests, auto-releases seats left away too long (striking the owner), bans
// students whose strike count reaches the threshold, and exposes a time base.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   Student_No, Seat_No      requesting student and target seat
//   write, Seat_State        request strobe and requested state (0 rel, 1 away, 2 occ)
//   write_set, limit_time,   settings strobe (1 ban, 2 limit, 3 clear strikes)
//   ban                      and the values it loads
//   Time                     free-running 11-bit tick counter
//   req_ok, req_fail         one-cycle result pulses, the cycle after a request
module school_seating_system #(
  parameter int NUM_SEATS = 32,
  parameter int NUM_STU   = 8,
  parameter int TICK_DIV  = 1,
  parameter int DEF_LIMIT = 5,
  parameter int DEF_BAN   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Student_No,
  input  logic [4:0]  Seat_No,
  input  logic        write,
  output logic [10:0] Time,
  input  logic [1:0]  Seat_State,
  input  logic [1:0]  write_set,
  input  logic [10:0] limit_time,
  input  logic [1:0]  ban,
  output logic        req_ok,
  output logic        req_fail
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (NUM_STU > 1) ? $clog2(NUM_STU) : 1;

  logic [DW-1:0]      div_q, div_d;
  logic [10:0]        time_q, time_d;
  logic [1:0]         state_q [NUM_SEATS];
  logic [1:0]         state_d [NUM_SEATS];
  logic [31:0]        owner_q [NUM_SEATS];
  logic [31:0]        owner_d [NUM_SEATS];
  logic [10:0]        stamp_q [NUM_SEATS];
  logic [10:0]        stamp_d [NUM_SEATS];
  logic [NUM_STU-1:0] vld_q, vld_d;
  logic [31:0]        sid_q [NUM_STU];
  logic [31:0]        sid_d [NUM_STU];
  logic [1:0]         cnt_q [NUM_STU];
  logic [1:0]         cnt_d [NUM_STU];
  logic [10:0]        lim_q, lim_d;
  logic [1:0]         thr_q, thr_d;
  logic               ok_q, ok_d, fail_q, fail_d;

  logic               tick, seat_ok, hit, banned, holds, accept;
  logic [SW-1:0]      slot;
  logic [10:0]        elapsed;

  assign tick    = (div_q == DW'(TICK_DIV - 1));
  assign seat_ok = ({27'd0, Seat_No} < 32'(NUM_SEATS));

  always_comb begin
    div_d   = tick ? '0 : div_q + DW'(1);
    time_d  = tick ? time_q + 11'd1 : time_q;
    state_d = state_q;
    owner_d = owner_q;
    stamp_d = stamp_q;
    vld_d   = vld_q;
    sid_d   = sid_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    thr_d   = thr_q;
    hit     = 1'b0;
    slot    = '0;
    banned  = 1'b0;
    holds   = 1'b0;
    accept  = 1'b0;
    elapsed = '0;

    // Timeout pass runs first so a same-cycle request sees the freed seat and
    // the updated strike counts.
    for (int s = 0; s < NUM_SEATS; s++) begin
      elapsed = time_q - stamp_q[s];
      if (state_q[s] == 2'd1 && elapsed >= lim_q) begin
        state_d[s] = 2'd0;
        owner_d[s] = '0;
        hit  = 1'b0;
        slot = '0;
        // Lowest free entry; stays at entry 0 when the table is full.
        for (int k = NUM_STU - 1; k >= 0; k--)
          if (!vld_d[k]) slot = SW'(k);
        for (int k = 0; k < NUM_STU; k++)
          if (vld_d[k] && sid_d[k] == owner_q[s]) begin
            hit  = 1'b1;
            slot = SW'(k);
          end
        if (hit) begin
          if (cnt_d[slot] != 2'd3) cnt_d[slot] = cnt_d[slot] + 2'd1;
        end else begin
          vld_d[slot] = 1'b1;
          sid_d[slot] = owner_q[s];
          cnt_d[slot] = 2'd1;
        end
      end
    end

    for (int k = 0; k < NUM_STU; k++)
      if (vld_d[k] && sid_d[k] == Student_No && thr_q != 2'd0 && cnt_d[k] >= thr_q)
        banned = 1'b1;
    for (int s = 0; s < NUM_SEATS; s++)
      if (state_d[s] != 2'd0 && owner_d[s] == Student_No) holds = 1'b1;

    if (write && seat_ok) begin
      case (Seat_State)
        2'd2: if (!banned) begin
          if (state_d[Seat_No] == 2'd0) begin
            if (!holds) begin
              state_d[Seat_No] = 2'd2;
              owner_d[Seat_No] = Student_No;
              stamp_d[Seat_No] = time_q;
              accept = 1'b1;
            end
          end else if (owner_d[Seat_No] == Student_No) begin
            state_d[Seat_No] = 2'd2;
            accept = 1'b1;
          end
        end
        2'd1: if (state_d[Seat_No] == 2'd2 && owner_d[Seat_No] == Student_No) begin
          state_d[Seat_No] = 2'd1;
          stamp_d[Seat_No] = time_q;
          accept = 1'b1;
        end
        2'd0: if (state_d[Seat_No] != 2'd0 && owner_d[Seat_No] == Student_No) begin
          state_d[Seat_No] = 2'd0;
          owner_d[Seat_No] = '0;
          accept = 1'b1;
        end
        default: accept = 1'b0;
      endcase
    end
    ok_d   = write & accept;
    fail_d = write & ~accept;

    // Clearing strikes also discards any strikes raised in this same cycle.
    case (write_set)
      2'd1:    thr_d = ban;
      2'd2:    lim_d = limit_time;
      2'd3:    vld_d = '0;
      default: thr_d = thr_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      time_q <= '0;
      vld_q  <= '0;
      lim_q  <= 11'(DEF_LIMIT);
      thr_q  <= 2'(DEF_BAN);
      ok_q   <= 1'b0;
      fail_q <= 1'b0;
      for (int s = 0; s < NUM_SEATS; s++) begin
        state_q[s] <= '0;
        owner_q[s] <= '0;
        stamp_q[s] <= '0;
      end
      for (int k = 0; k < NUM_STU; k++) begin
        sid_q[k] <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      div_q   <= div_d;
      time_q  <= time_d;
      state_q <= state_d;
      owner_q <= owner_d;
      stamp_q <= stamp_d;
      vld_q   <= vld_d;
      sid_q   <= sid_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      thr_q   <= thr_d;
      ok_q    <= ok_d;
      fail_q  <= fail_d;
    end
  end

  assign Time     = time_q;
  assign req_ok   = ok_q;
  assign req_fail = fail_q;

endmodule

// File: tb/tb_school_seating_system.sv
// tb/tb_school_seating_system.sv - randomized self-checking bench for school_seating_system
module tb_school_seating_system;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Student_No;
  logic [4:0]  Seat_No;
  logic        write;
  logic [10:0] Time;
  logic [1:0]  Seat_State;
  logic [1:0]  write_set;
  logic [10:0] limit_time;
  logic [1:0]  ban;
  logic        req_ok;
  logic        req_fail;

  always #5 clk = ~clk;

  school_seating_system dut (
    .clk        (clk),
    .rst        (rst),
    .Student_No (Student_No),
    .Seat_No    (Seat_No),
    .write      (write),
    .Time       (Time),
    .Seat_State (Seat_State),
    .write_set  (write_set),
    .limit_time (limit_time),
    .ban        (ban),
    .req_ok     (req_ok),
    .req_fail   (req_fail)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: seat table plus an allocation-ordered strike list.
  int          m_state [32];
  logic [31:0] m_owner [32];
  int          m_stamp [32];
  logic [31:0] m_ids[$];
  int          m_cnt[$];
  int          m_time, m_lim, m_thr;

  function automatic void model_reset();
    for (int s = 0; s < 32; s++) begin
      m_state[s] = 0;
      m_owner[s] = 0;
      m_stamp[s] = 0;
    end
    m_ids.delete();
    m_cnt.delete();
    m_time = 0;
    m_lim  = 5;
    m_thr  = 2;
  endfunction

  function automatic int strikes_of(logic [31:0] id);
    for (int k = 0; k < m_ids.size(); k++)
      if (m_ids[k] == id) return m_cnt[k];
    return 0;
  endfunction

  function automatic void add_strike(logic [31:0] id);
    for (int k = 0; k < m_ids.size(); k++)
      if (m_ids[k] == id) begin
        if (m_cnt[k] < 3) m_cnt[k] = m_cnt[k] + 1;
        return;
      end
    if (m_ids.size() < 8) begin
      m_ids.push_back(id);
      m_cnt.push_back(1);
    end else begin
      m_ids[0] = id;
      m_cnt[0] = 1;
    end
  endfunction

  function automatic bit model_req(logic [31:0] id, int seat, int st);
    bit banned;
    bit holds;
    banned = (m_thr != 0) && (strikes_of(id) >= m_thr);
    holds  = 1'b0;
    for (int s = 0; s < 32; s++)
      if (m_state[s] != 0 && m_owner[s] == id) holds = 1'b1;
    if (st == 2) begin
      if (banned) return 1'b0;
      if (m_state[seat] == 0) begin
        if (holds) return 1'b0;
        m_state[seat] = 2;
        m_owner[seat] = id;
        m_stamp[seat] = m_time;
        return 1'b1;
      end
      if (m_owner[seat] == id) begin
        m_state[seat] = 2;
        return 1'b1;
      end
      return 1'b0;
    end else if (st == 1) begin
      if (m_state[seat] == 2 && m_owner[seat] == id) begin
        m_state[seat] = 1;
        m_stamp[seat] = m_time;
        return 1'b1;
      end
      return 1'b0;
    end else if (st == 0) begin
      if (m_state[seat] != 0 && m_owner[seat] == id) begin
        m_state[seat] = 0;
        m_owner[seat] = 0;
        return 1'b1;
      end
      return 1'b0;
    end
    return 1'b0;
  endfunction

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit wr, input logic [31:0] id, input int seat, input int st,
                       input int ws, input int lim, input int bn, output bit ok_seen);
    bit          ok;
    logic [31:0] prev;
    write      = wr;
    Student_No = id;
    Seat_No    = seat[4:0];
    Seat_State = st[1:0];
    write_set  = ws[1:0];
    limit_time = lim[10:0];
    ban        = bn[1:0];
    for (int s = 0; s < 32; s++)
      if (m_state[s] == 1 && ((m_time - m_stamp[s] + 2048) % 2048) >= m_lim) begin
        prev       = m_owner[s];
        m_state[s] = 0;
        m_owner[s] = 0;
        add_strike(prev);
      end
    ok = wr ? model_req(id, seat, st) : 1'b0;
    if (ws == 1) m_thr = bn;
    if (ws == 2) m_lim = lim;
    if (ws == 3) begin
      m_ids.delete();
      m_cnt.delete();
    end
    m_time = (m_time + 1) % 2048;
    @(posedge clk);
    #1;
    check("time", 32'(Time), 32'(m_time));
    check("req_ok", 32'(req_ok), 32'(wr && ok));
    check("req_fail", 32'(req_fail), 32'(wr && !ok));
    ok_seen = req_ok;
  endtask

  task automatic req(input logic [31:0] id, input int seat, input int st, output bit ok_seen);
    cycle(1'b1, id, seat, st, 0, 0, 0, ok_seen);
  endtask

  task automatic idle(input int n);
    bit d;
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 0, 0, 0, 0, 0, d);
  endtask

  task automatic set(input int ws, input int lim, input int bn);
    bit d;
    cycle(1'b0, 32'd0, 0, 0, ws, lim, bn, d);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    write     = 1'b0;
    write_set = 2'd0;
    #3;
    check("rst_time", 32'(Time), 32'd0);
    check("rst_ok", 32'(req_ok), 32'd0);
    check("rst_fail", 32'(req_fail), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  logic [31:0] pool [12];
  bit          r;
  int          rseat, rst_sel, rws;

  initial begin
    rst        = 1'b1;
    Student_No = '0;
    Seat_No    = '0;
    write      = 1'b0;
    Seat_State = '0;
    write_set  = '0;
    limit_time = '0;
    ban        = '0;
    for (int i = 0; i < 12; i++) pool[i] = 32'd1000 + 32'(i * 7);
    pool[11] = 32'd0;
    do_reset();

    // Basic occupy contention
    req(201819186, 1, 2, r); check("t1_occ", 32'(r), 1);
    req(201912352, 1, 2, r); check("t1_taken", 32'(r), 0);

    // Away timeout at default limit frees the seat and strikes the owner
    req(201912352, 2, 2, r); check("t2_occ", 32'(r), 1);
    req(201912352, 2, 1, r); check("t2_away", 32'(r), 1);
    idle(6);
    req(201912352, 2, 0, r); check("t2_freed", 32'(r), 0);
    req(201912352, 2, 2, r); check("t2_reocc", 32'(r), 1);

    // Longer limit: short away then return, then cannot take a second seat
    set(2, 15, 0);
    req(300, 5, 2, r); check("t3_occ", 32'(r), 1);
    req(300, 5, 1, r); check("t3_away", 32'(r), 1);
    idle(2);
    req(300, 5, 2, r); check("t3_back", 32'(r), 1);
    req(300, 3, 2, r); check("t3_second", 32'(r), 0);

    // Ownership checks on release
    req(201912379, 4, 2, r); check("t4_occ", 32'(r), 1);
    req(201912379, 7, 2, r); check("t4_second", 32'(r), 0);
    req(201819186, 4, 0, r); check("t4_rel_other", 32'(r), 0);
    req(201912379, 4, 0, r); check("t4_rel_own", 32'(r), 1);
    req(201912379, 4, 3, r); check("t4_illegal", 32'(r), 0);

    // Ban by threshold, lifted by clearing strikes
    req(400, 8, 2, r); check("t5_occ", 32'(r), 1);
    req(400, 8, 1, r); check("t5_away", 32'(r), 1);
    idle(17);
    set(1, 0, 1);
    req(400, 6, 2, r); check("t5_banned", 32'(r), 0);
    set(3, 0, 0);
    req(400, 6, 2, r); check("t5_cleared", 32'(r), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rseat   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      rst_sel = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      rws     = ($urandom_range(0, 99) < 3) ? int'($urandom_range(1, 3)) : 0;
      cycle($urandom_range(0, 99) < 75, pool[$urandom_range(0, 11)], rseat, rst_sel, rws,
            int'($urandom_range(0, 12)), int'($urandom_range(0, 3)), r);
    end

    // Time wrap: away at stamp 2045 with limit 5 releases at Time 2
    do_reset();
    while (m_time != 2044) idle(1);
    req(500, 9, 2, r); check("t6_occ", 32'(r), 1);
    req(500, 9, 1, r); check("t6_away", 32'(r), 1);
    while (m_time != 1) idle(1);
    req(501, 9, 2, r); check("t6_not_yet", 32'(r), 0);
    req(501, 9, 2, r); check("t6_released", 32'(r), 1);
    req(501, 9, 1, r); check("t6_away2", 32'(r), 1);

    // Asynchronous reset mid-run frees everything
    do_reset();
    req(502, 9, 2, r); check("t6_after_rst", 32'(r), 1);
    check("t6_time", 32'(Time), 32'd1);

    write = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
